// File: rtl/rtc_i2c_sequencer.sv
// rtc_i2c_sequencer: keeps a shadow of the RTC seconds/minutes/hours bytes fresh
// through i2c_api, and shares the same command port with single-byte UI writes.
module rtc_i2c_sequencer #(
  parameter int unsigned CLK_FREQ    = 25_000_000,
  parameter int unsigned POLL_PERIOD = 2_500_000,
  parameter int unsigned TIMEOUT     = 250_000,
  parameter logic [6:0]  SLAVE_ADDR  = 7'h68,
  parameter logic [7:0]  REG_BASE    = 8'h00,
  parameter logic [7:0]  FN_IDLE     = 8'h00,
  parameter logic [7:0]  FN_READ_U8  = 8'h01,
  parameter logic [7:0]  FN_WRITE_8  = 8'h11
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       wr_req,
  input  logic [7:0] wr_reg,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic [7:0] rtc_sec,
  output logic [7:0] rtc_min,
  output logic [7:0] rtc_hour,
  output logic       time_valid,
  output logic       busy,
  output logic       err,
  output logic       api_enable,
  output logic [6:0] api_slave_addr,
  output logic [7:0] api_function,
  output logic [7:0] api_register,
  output logic [7:0] api_data_tx,
  input  logic [7:0] api_data_rx,
  input  logic       api_ready,
  input  logic       api_done
);

  localparam int unsigned   PW        = $clog2(POLL_PERIOD);
  localparam int unsigned   TW        = $clog2(TIMEOUT);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  // A nonsensical configuration keeps i2c_api disabled rather than misbehaving.
  localparam bit            CFG_OK    = (CLK_FREQ > 0) && (POLL_PERIOD > 1) && (TIMEOUT > 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   timer_q, timer_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            pending_q, pending_d;
  logic            is_write_q, is_write_d;
  logic            aborted_q, aborted_d;
  logic [1:0]      idx_q, idx_d;
  logic            gap_q, gap_d;
  logic [7:0]      wreg_q, wreg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic [2:0][7:0] shadow_q, shadow_d;
  logic [7:0]      fn_q, fn_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      sec_q, sec_d;
  logic [7:0]      min_q, min_d;
  logic [7:0]      hour_q, hour_d;
  logic            tv_q, tv_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            en_q;
  logic            timer_wrap_s;
  logic            poll_start_s;
  logic            poll_busy_s;

  // State and output registers; reset aborts any command without committing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      tmo_q      <= '0;
      pending_q  <= 1'b1;
      is_write_q <= 1'b0;
      aborted_q  <= 1'b0;
      idx_q      <= 2'd0;
      gap_q      <= 1'b0;
      wreg_q     <= 8'h00;
      wdata_q    <= 8'h00;
      shadow_q   <= '0;
      fn_q       <= FN_IDLE;
      reg_q      <= 8'h00;
      tx_q       <= 8'h00;
      sec_q      <= 8'h00;
      min_q      <= 8'h00;
      hour_q     <= 8'h00;
      tv_q       <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tmo_q      <= tmo_d;
      pending_q  <= pending_d;
      is_write_q <= is_write_d;
      aborted_q  <= aborted_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      shadow_q   <= shadow_d;
      fn_q       <= fn_d;
      reg_q      <= reg_d;
      tx_q       <= tx_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      tv_q       <= tv_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      en_q       <= CFG_OK;
    end
  end

  // Poll timer, arbitration and command sequencing.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    is_write_d   = is_write_q;
    aborted_d    = aborted_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    wreg_d       = wreg_q;
    wdata_d      = wdata_q;
    shadow_d     = shadow_q;
    fn_d         = fn_q;
    reg_d        = reg_q;
    tx_d         = tx_q;
    sec_d        = sec_q;
    min_d        = min_q;
    hour_d       = hour_q;
    tv_d         = 1'b0;
    ack_d        = 1'b0;
    err_d        = err_q;
    poll_start_s = 1'b0;
    poll_busy_s  = (state_q != S_IDLE) && !is_write_q;
    timer_wrap_s = (timer_q == POLL_LAST);
    timer_d      = timer_wrap_s ? '0 : timer_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        // The request is still high while the ack is visible; never re-accept it then.
        if (wr_req && !ack_q) begin
          wreg_d     = wr_reg;
          wdata_d    = wr_data;
          is_write_d = 1'b1;
          aborted_d  = 1'b0;
          state_d    = S_ISSUE;
        end else if (pending_q) begin
          poll_start_s = 1'b1;
          is_write_d   = 1'b0;
          aborted_d    = 1'b0;
          idx_d        = 2'd0;
          state_d      = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (api_ready) begin
          fn_d    = is_write_q ? FN_WRITE_8 : FN_READ_U8;
          reg_d   = is_write_q ? wreg_q : REG_BASE + {6'b000000, idx_q};
          tx_d    = is_write_q ? wdata_q : 8'h00;
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (api_done) begin
          fn_d    = FN_IDLE;
          gap_d   = 1'b0;
          state_d = S_GAP;
          if (!is_write_q) begin
            shadow_d[idx_q] = api_data_rx;
          end else begin
            shadow_d = shadow_q;
          end
        end else if (tmo_q == TMO_LAST) begin
          fn_d      = FN_IDLE;
          err_d     = 1'b1;
          aborted_d = 1'b1;
          gap_d     = 1'b0;
          state_d   = S_GAP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_GAP: begin
        if (!gap_q) begin
          gap_d = 1'b1;
        end else if (is_write_q) begin
          ack_d   = 1'b1;
          state_d = S_IDLE;
        end else if (aborted_q) begin
          state_d = S_IDLE;
        end else if (idx_q != 2'd2) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_ISSUE;
        end else begin
          sec_d   = shadow_q[0];
          min_d   = shadow_q[1];
          hour_d  = shadow_q[2];
          tv_d    = 1'b1;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // An expiry during a running poll is dropped; the pending flag never counts past one.
    if (poll_start_s) begin
      pending_d = 1'b0;
    end else if (timer_wrap_s && !poll_busy_s) begin
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign wr_ack         = ack_q;
  assign rtc_sec        = sec_q;
  assign rtc_min        = min_q;
  assign rtc_hour       = hour_q;
  assign time_valid     = tv_q;
  assign busy           = busy_q;
  assign err            = err_q;
  assign api_enable     = en_q;
  assign api_slave_addr = SLAVE_ADDR;
  assign api_function   = fn_q;
  assign api_register   = reg_q;
  assign api_data_tx    = tx_q;

endmodule

// File: doc/rtc_i2c_sequencer.md
Name: rtc_i2c_sequencer

Overview:
- Drives the i2c_api command port to keep a shadow copy of the RTC time registers (seconds, minutes, hours, BCD) refreshed on a fixed poll period.
- Arbitrates between that periodic poll and single-register write requests from the clock/alarm UI logic, so the one i2c_api instance is shared safely.
- Sits between the UI/display logic and i2c_api. It sequences commands only and never touches scl/sda.

Parameters:
- CLK_FREQ, 25_000_000, system clock in Hz; documents the clock that POLL_PERIOD and TIMEOUT are counted in.
- POLL_PERIOD, 2_500_000, cycles between poll starts (100 ms at 25 MHz).
- TIMEOUT, 250_000, max cycles to wait for api_done per command.
- SLAVE_ADDR, 7'h68, RTC 7-bit I2C address.
- REG_BASE, 8'h00, first time register; the poll reads REG_BASE, REG_BASE+1, REG_BASE+2.
- FN_IDLE / FN_READ_U8 / FN_WRITE_8: command codes. Defaults are the I2C_NOP-free idle code, I2C_READ_U8 and I2C_WRITE_8 from i2c_api.vh. FN_IDLE is any code i2c_api treats as "no command".

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- wr_req  in  1  level write request; held until wr_ack
- wr_reg  in  8  register for write; stable while wr_req
- wr_data  in  8  byte for write; stable while wr_req
- wr_ack  out  1  one-cycle pulse when the write command completes (or times out)
- rtc_sec / rtc_min / rtc_hour  out  8 each  committed shadow bytes
- time_valid  out  1  one-cycle pulse when a poll commits new shadow bytes
- busy  out  1  high whenever the FSM is not in IDLE
- err  out  1  sticky timeout flag
- api_enable  out  1  to i2c_api enable
- api_slave_addr  out  7  to i2c_api slave_addr
- api_function  out  8  to i2c_api i2c_function
- api_register  out  8  to i2c_api device_register
- api_data_tx  out  8  to i2c_api data_tx
- api_data_rx  in  8  from i2c_api data_rx
- api_ready  in  1  from i2c_api ready
- api_done  in  1  from i2c_api done

Behaviour:
- Reset (async):
  - All outputs are registered.
  - On reset: api_function=FN_IDLE; api_enable, busy, err, wr_ack, time_valid = 0; rtc_* = 0; poll timer = 0.
  - poll_pending is set to 1, so the first poll starts immediately after reset release.
  - api_enable goes 1 on the first clock after reset release.
  - Reset mid-command aborts instantly; nothing is committed.
- Constant outputs: api_slave_addr=SLAVE_ADDR at all times.
- Poll timer:
  - Free-running, width $clog2(POLL_PERIOD).
  - Wraps at POLL_PERIOD-1 and sets poll_pending.
  - Expiry while pending is already set, or while a poll is in flight, does not queue a second poll.
- FSM states:
  - IDLE
    - Arbitration point: wr_req has priority over poll_pending.
    - Write selected: latch wr_reg/wr_data, op=WRITE, go to ISSUE.
    - Poll selected: clear poll_pending, idx=0, op=READ, go to ISSUE.
  - ISSUE
    - Wait for api_ready=1.
    - Then drive api_function (FN_WRITE_8 or FN_READ_U8), api_register (latched wr_reg, or REG_BASE+idx), api_data_tx.
    - Clear the timeout counter; go to WAIT.
  - WAIT
    - Hold the command until api_done is sampled 1.
    - On that edge: api_function<=FN_IDLE. For a read, capture api_data_rx into shadow[idx]. Go to GAP.
    - If the timeout counter reaches TIMEOUT-1 first: api_function<=FN_IDLE, err<=1, discard shadow, go to GAP with op marked aborted.
  - GAP
    - Holds FN_IDLE for exactly 2 cycles so i2c_api returns to its idle state without re-triggering.
    - Then one of:
      - READ with idx<2: idx+1, back to ISSUE.
      - READ with idx==2 (not aborted): commit shadow to rtc_sec/min/hour all on one edge, pulse time_valid, clear err; go to IDLE.
      - WRITE (including an aborted write): pulse wr_ack; go to IDLE.
      - Aborted READ: go to IDLE with no commit and no time_valid.
- Polls are atomic: wr_req arriving mid-poll waits for IDLE. Reads never interleave with a write.
- Minimum spacing between consecutive commands is 2 FN_IDLE cycles.
- Only a successful poll clears err.

Test Plan:
- Poll data path: POLL_PERIOD=1000, TIMEOUT=500, bench model returns done 20 cycles after command with rx 0x45, 0x30, 0x12.
  -> after reset, registers 0x00, 0x01, 0x02 are read in order.
  -> rtc_sec=0x45, rtc_min=0x30, rtc_hour=0x12, with one time_valid pulse.
  -> next poll starts 1000 cycles after the previous one.
- Write path: wr_req with wr_reg=0x01, wr_data=0x59 while idle.
  -> one FN_WRITE_8 command with register 0x01 and data_tx 0x59; wr_ack pulses once; wr_req dropped -> no repeat.
- Arbitration: wr_req asserted at cycle 5 of an in-flight poll.
  -> all 3 reads complete and commit first, then the write issues.
  -> wr_req and poll_pending set on the same cycle -> write issues first.
- Timeout: model never asserts done on the 2nd poll read.
  -> FN_IDLE 500 cycles after issue; err=1; rtc_* unchanged; no time_valid.
  -> next poll succeeds -> err=0.
- Handshake timing: after each done, api_function=FN_IDLE for ≥2 cycles; the model counts exactly 3 commands per poll (no double issue). api_ready held low 50 cycles -> ISSUE waits, no command driven.
- Async reset mid-WAIT: api_function=FN_IDLE and busy=0 immediately, no commit; a poll starts right after release.
